dist_ram_fifo: RTL and testbench

- Synchronous FIFO built on the team's distributed-RAM storage model: a 2^DEPTH_LOG2 × WIDTH array with synchronous write and asynchronous read, followed by one registered output stage.
- Acts as the reader/consumer counterpart of the dual-port select-RAM primitive.
- Write side writes through the write address; read side drains through the independent read address.
- Used as a small elastic buffer between valid/ready streams inside one clock domain.

---
 rtl/dist_ram_fifo_if.sv | 35 +++
 rtl/dist_ram_fifo.sv | 126 ++++++++++++
 tb/tb_dist_ram_fifo.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dist_ram_fifo_if.sv
// Stream bundle for dist_ram_fifo: write side (S_*), read side (M_*) and fill level.
// ALMOST_FULL/ALMOST_EMPTY exist only when DIST_RAM_FIFO_ALMOST_EN is defined.
interface dist_ram_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5
);
  logic                    S_VALID;
  logic                    S_READY;
  logic [WIDTH-1:0]        S_DATA;
  logic                    M_VALID;
  logic                    M_READY;
  logic [WIDTH-1:0]        M_DATA;
  logic [DEPTH_LOG2+1:0]   LEVEL;
`ifdef DIST_RAM_FIFO_ALMOST_EN
  logic                    ALMOST_FULL;
  logic                    ALMOST_EMPTY;
`endif

  // master: producer/consumer around the FIFO; slave: the FIFO itself
  modport master (
    output S_VALID, S_DATA, M_READY,
    input  S_READY, M_VALID, M_DATA, LEVEL
`ifdef DIST_RAM_FIFO_ALMOST_EN
    , input ALMOST_FULL, ALMOST_EMPTY
`endif
  );

  modport slave (
    input  S_VALID, S_DATA, M_READY,
    output S_READY, M_VALID, M_DATA, LEVEL
`ifdef DIST_RAM_FIFO_ALMOST_EN
    , output ALMOST_FULL, ALMOST_EMPTY
`endif
  );
endinterface

// File: rtl/dist_ram_fifo.sv
// Async-read RAM FIFO plus one output register; write-to-M_VALID latency 2 edges, capacity 2^DEPTH_LOG2+1.
// S_READY depends only on registered RAM occupancy; optional flags under DIST_RAM_FIFO_ALMOST_EN.
module dist_ram_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5,
  parameter int AFULL_THR  = 28,
  parameter int AEMPTY_THR = 2
) (
  input  logic           CLK,
  input  logic           RSTN,
  dist_ram_fifo_if.slave bus
);

  localparam int LW = DEPTH_LOG2 + 2;
  localparam logic [DEPTH_LOG2:0]   RAM_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

  if (WIDTH < 1 || WIDTH > 64 || DEPTH_LOG2 < 4 || DEPTH_LOG2 > 6 ||
      AFULL_THR < 0 || AEMPTY_THR < 0) begin : g_bad_param
    $error("dist_ram_fifo: parameter out of range");
  end

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   ram_count_q, ram_count_d;
  logic                  m_valid_q, m_valid_d;
  logic [WIDTH-1:0]      m_data_q, m_data_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  s_ready;
  logic                  wr_en;
  logic                  ld_en;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;

    s_ready = (ram_count_q != RAM_DEPTH);
    wr_en   = bus.S_VALID & s_ready;
    // refill the output register whenever it is empty or being consumed
    ld_en   = (~m_valid_q | bus.M_READY) & (ram_count_q != '0);

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (ld_en) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      m_valid_d = 1'b1;
      m_data_d  = mem[rd_ptr_q];
    end else if (m_valid_q & bus.M_READY) begin
      m_valid_d = 1'b0;
    end

    case ({wr_en, ld_en})
      2'b10:   ram_count_d = ram_count_q + CNT_ONE;
      2'b01:   ram_count_d = ram_count_q - CNT_ONE;
      default: ram_count_d = ram_count_q;
    endcase

    level_d = LW'(ram_count_d) + LW'(m_valid_d);
  end

  // storage is deliberately not reset; pointers make stale words unreachable
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.S_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      level_q     <= level_d;
    end
  end

  assign bus.S_READY = s_ready;
  assign bus.M_VALID = m_valid_q;
  assign bus.M_DATA  = m_data_q;
  assign bus.LEVEL   = level_q;

`ifdef DIST_RAM_FIFO_ALMOST_EN
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THR);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THR);

  logic afull_q, afull_d;
  logic aempty_q, aempty_d;

  // flags track the level being registered this edge, so they move with LEVEL
  always_comb begin
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign bus.ALMOST_FULL  = afull_q;
  assign bus.ALMOST_EMPTY = aempty_q;
`endif

endmodule

// File: tb/tb_dist_ram_fifo.sv
// Directed bench for dist_ram_fifo (WIDTH=8, DEPTH_LOG2=5): single word, fill/full, stream, reset.
// Flag checks compile in only with DIST_RAM_FIFO_ALMOST_EN.
module tb_dist_ram_fifo;

  logic CLK;
  logic RSTN;
  int   total;
  int   bad;

  dist_ram_fifo_if #(.WIDTH(8), .DEPTH_LOG2(5)) bus ();

  dist_ram_fifo #(
    .WIDTH(8), .DEPTH_LOG2(5), .AFULL_THR(28), .AEMPTY_THR(2)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_d;
    int sent;
    int rcv;
    int gaps;
    int first_cyc;
    logic acc;

    total = 0;
    bad   = 0;
    RSTN  = 1'b0;
    bus.S_VALID = 1'b0;
    bus.S_DATA  = 8'h00;
    bus.M_READY = 1'b0;

    // reset state
    #12;
    chk("rst_mvalid", bus.M_VALID, 0);
    chk("rst_level",  bus.LEVEL,   0);
    chk("rst_mdata",  bus.M_DATA,  0);
`ifdef DIST_RAM_FIFO_ALMOST_EN
    chk("rst_afull",  bus.ALMOST_FULL,  0);
    chk("rst_aempty", bus.ALMOST_EMPTY, 1);
`endif
    #1 RSTN = 1'b1;
    #1;
    chk("rst_sready", bus.S_READY, 1);

    // single word
    bus.S_VALID = 1'b1;
    bus.S_DATA  = 8'hA5;
    tick();
    bus.S_VALID = 1'b0;
    chk("sw_mvalid_n", bus.M_VALID, 0);
    chk("sw_level_n",  bus.LEVEL,   1);
    tick();
    chk("sw_mvalid", bus.M_VALID, 1);
    chk("sw_mdata",  bus.M_DATA,  8'hA5);
    chk("sw_level",  bus.LEVEL,   1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sw_hold_v", bus.M_VALID, 1);
      chk("sw_hold_d", bus.M_DATA,  8'hA5);
    end
    bus.M_READY = 1'b1;
    tick();
    bus.M_READY = 1'b0;
    chk("sw_pop_v",     bus.M_VALID, 0);
    chk("sw_pop_level", bus.LEVEL,   0);
    chk("sw_pop_hold",  bus.M_DATA,  8'hA5);

    // fill to full: 33 words 0x00..0x20
    for (int k = 1; k <= 33; k++) begin
      bus.S_VALID = 1'b1;
      bus.S_DATA  = 8'(k - 1);
      chk("fill_rdy", bus.S_READY, 1);
      tick();
`ifdef DIST_RAM_FIFO_ALMOST_EN
      if (k == 2)  chk("ae_at2",  bus.ALMOST_EMPTY, 1);
      if (k == 3)  chk("ae_at3",  bus.ALMOST_EMPTY, 0);
      if (k == 27) chk("af_at27", bus.ALMOST_FULL,  0);
      if (k == 28) chk("af_at28", bus.ALMOST_FULL,  1);
`endif
    end
    bus.S_VALID = 1'b0;
    chk("full_sready", bus.S_READY, 0);
    chk("full_level",  bus.LEVEL,   33);
    chk("full_mdata",  bus.M_DATA,  8'h00);

    // write attempt while full is refused
    bus.S_VALID = 1'b1;
    bus.S_DATA  = 8'hFF;
    tick();
    chk("blk_level", bus.LEVEL,  33);
    chk("blk_mdata", bus.M_DATA, 8'h00);

    // full with simultaneous read: no write, slot frees next cycle
    bus.S_DATA  = 8'h77;
    bus.M_READY = 1'b1;
    tick();
    chk("sim_sready", bus.S_READY, 1);
    chk("sim_level",  bus.LEVEL,   32);
    chk("sim_mdata",  bus.M_DATA,  8'h01);
    bus.M_READY = 1'b0;
    tick();
    bus.S_VALID = 1'b0;
    chk("sim_refill_level", bus.LEVEL,   33);
    chk("sim_refill_rdy",   bus.S_READY, 0);

    // drain: 0x01..0x20 then 0x77
    bus.M_READY = 1'b1;
    for (int k = 0; k < 33; k++) begin
      exp_d = (k < 32) ? 8'(k + 1) : 8'h77;
      chk("drain_v",   bus.M_VALID, 1);
      chk("drain_d",   bus.M_DATA,  exp_d);
      chk("drain_lvl", bus.LEVEL,   33 - k);
`ifdef DIST_RAM_FIFO_ALMOST_EN
      if (k == 30) chk("ae_drain3", bus.ALMOST_EMPTY, 0);
      if (k == 31) chk("ae_drain2", bus.ALMOST_EMPTY, 1);
`endif
      tick();
    end
    bus.M_READY = 1'b0;
    chk("drain_end_v",   bus.M_VALID, 0);
    chk("drain_end_lvl", bus.LEVEL,   0);

    // streaming 100 words through several pointer wraps
    sent = 0;
    rcv = 0;
    gaps = 0;
    first_cyc = -1;
    bus.S_VALID = 1'b1;
    bus.S_DATA  = 8'h00;
    bus.M_READY = 1'b1;
    for (int cyc = 1; cyc <= 110 && rcv < 100; cyc++) begin
      acc = bus.S_VALID & bus.S_READY;
      tick();
      if (acc) sent++;
      bus.S_DATA = 8'(sent);
      if (sent == 100) bus.S_VALID = 1'b0;
      if (bus.M_VALID) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("stream_d", bus.M_DATA, 8'(rcv));
        rcv++;
      end else if (rcv > 0) begin
        gaps++;
      end
    end
    chk("stream_count", rcv, 100);
    chk("stream_gaps",  gaps, 0);
    chk("stream_first", first_cyc, 2);
    tick();
    bus.M_READY = 1'b0;
    chk("stream_end_v",   bus.M_VALID, 0);
    chk("stream_end_lvl", bus.LEVEL,   0);

    // reset mid-operation with 10 words queued
    for (int k = 0; k < 10; k++) begin
      bus.S_VALID = 1'b1;
      bus.S_DATA  = 8'(8'h10 + k);
      tick();
    end
    bus.S_VALID = 1'b0;
    chk("mr_pre_level", bus.LEVEL, 10);
    RSTN = 1'b0;
    #2;
    chk("mr_mvalid", bus.M_VALID, 0);
    chk("mr_level",  bus.LEVEL,   0);
    chk("mr_mdata",  bus.M_DATA,  0);
`ifdef DIST_RAM_FIFO_ALMOST_EN
    chk("mr_afull",  bus.ALMOST_FULL,  0);
    chk("mr_aempty", bus.ALMOST_EMPTY, 1);
`endif
    #1 RSTN = 1'b1;
    bus.S_VALID = 1'b1;
    bus.S_DATA  = 8'h5A;
    tick();
    bus.S_VALID = 1'b0;
    tick();
    chk("mr_new_v",   bus.M_VALID, 1);
    chk("mr_new_d",   bus.M_DATA,  8'h5A);
    chk("mr_new_lvl", bus.LEVEL,   1);
    bus.M_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_stale_v", bus.M_VALID, 0);
      chk("mr_no_stale_l", bus.LEVEL,   0);
    end
    bus.M_READY = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
